// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the constant log2 helper used to size the step counter.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_e;

   // Ceiling log2; clog2(n) is the number of bits needed to hold 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mult_sign_adj.sv
// Combinational conditional two's-complement negate. Used as |v| on the
// operands (neg_i = sign bit) and as the final product sign fix-up.
module mult_sign_adj #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic         neg_i,
   output logic [W-1:0] y_o
);

   assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/multiplier_seq.sv
// Sequential radix-2 shift-add multiplier with start/busy/done handshake;
// signed mode multiplies magnitudes and negates the product at the end.
module multiplier_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 cclk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sign_mode,
   input  logic [WIDTH-1:0]     X,
   input  logic [WIDTH-1:0]     Y,
   output logic [2*WIDTH-1:0]   Z,
   output logic                 busy,
   output logic                 done
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_e           state_q;
   logic [PW-1:0]    mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    z_q;
   logic [CW-1:0]    cnt_q;
   logic             neg_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] x_mag;
   logic [WIDTH-1:0] y_mag;
   logic [PW-1:0]    acc_d;
   logic [PW-1:0]    z_d;

   // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is the right unsigned magnitude.
   mult_sign_adj #(.W(WIDTH)) u_abs_x (
      .a_i  (X),
      .neg_i(sign_mode & X[WIDTH-1]),
      .y_o  (x_mag)
   );

   mult_sign_adj #(.W(WIDTH)) u_abs_y (
      .a_i  (Y),
      .neg_i(sign_mode & Y[WIDTH-1]),
      .y_o  (y_mag)
   );

   mult_sign_adj #(.W(PW)) u_neg_z (
      .a_i  (acc_q),
      .neg_i(neg_q),
      .y_o  (z_d)
   );

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values; blocking would make order-dependent shortcuts.
   always_ff @(posedge cclk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         z_q      <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q  <= {{WIDTH{1'b0}}, x_mag};
                  mplier_q <= y_mag;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  neg_q    <= sign_mode & (X[WIDTH-1] ^ Y[WIDTH-1]);
                  busy_q   <= 1'b1;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST_STEP) state_q <= FIN;
            end
            FIN: begin
               z_q     <= z_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Z    = z_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq (WIDTH=8): transaction-level model
// compared every cycle, plus directed literal and randomised product checks.
module tb_multiplier_seq;

   localparam int W = 8;

   logic          cclk;
   logic          rst;
   logic          start;
   logic          sign_mode;
   logic [W-1:0]  X;
   logic [W-1:0]  Y;
   logic [2*W-1:0] Z;
   logic          busy;
   logic          done;

   int n_checks;
   int n_fail;
   bit chk_en;

   multiplier_seq #(.WIDTH(W)) dut (
      .cclk     (cclk),
      .rst      (rst),
      .start    (start),
      .sign_mode(sign_mode),
      .X        (X),
      .Y        (Y),
      .Z        (Z),
      .busy     (busy),
      .done     (done)
   );

   initial cclk = 1'b0;
   always #5 cclk = ~cclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
      longint p;
      if (s) p = longint'($signed(x)) * longint'($signed(y));
      else   p = longint'(x) * longint'(y);
      return p[2*W-1:0];
   endfunction

   // Transaction model: an accepted request makes the block busy for W+1
   // cycles, then publishes its product with a one-cycle done.
   int             m_left;
   logic [2*W-1:0] m_pending;
   logic [2*W-1:0] m_z;
   logic           m_done;

   always @(posedge cclk) begin
      if (rst) begin
         m_left = 0;
         m_z    = '0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_z    = m_pending;
               m_done = 1'b1;
            end
         end else if (start) begin
            m_pending = golden(X, Y, sign_mode);
            m_left    = W + 1;
         end
      end
   end

   always @(negedge cclk) begin
      if (chk_en)
         check("cycle {busy,done,Z}", {46'd0, busy, done, Z}, {46'd0, (m_left != 0), m_done, m_z});
   end

   // Launch one operation; returns Z at the done cycle, edges from acceptance
   // to done (-1 on timeout) and the number of busy cycles observed.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic hold, output logic [2*W-1:0] z, output int lat,
                         output int busy_n);
      start     = 1'b1;
      X         = x;
      Y         = y;
      sign_mode = s;
      @(posedge cclk);
      lat    = -1;
      busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge cclk);
         start     = hold;
         X         = W'($urandom);
         Y         = W'($urandom);
         sign_mode = 1'($urandom);
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_n++;
      end
      z = Z;
   endtask

   task automatic op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic s, input logic [2*W-1:0] exp_z, input logic hold);
      logic [2*W-1:0] z;
      int lat;
      int bn;
      run_op(x, y, s, hold, z, lat, bn);
      check(name, 64'(z), 64'(exp_z));
      check({name, " latency"}, 64'(lat), 64'(W + 1));
      if (!hold) check({name, " busy cycles"}, 64'(bn), 64'(W + 1));
   endtask

   initial begin
      logic [2*W-1:0] z;
      int lat;
      int bn;
      int done_seen;
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      logic rs;

      n_checks  = 0;
      n_fail    = 0;
      chk_en    = 1'b0;
      rst       = 1'b1;
      start     = 1'b0;
      sign_mode = 1'b0;
      X         = '0;
      Y         = '0;
      repeat (2) @(negedge cclk);
      rst    = 1'b0;
      chk_en = 1'b1;
      check("reset Z", 64'(Z), 64'h0);
      check("reset busy/done", {62'd0, busy, done}, 64'h0);

      // Directed unsigned and signed vectors.
      op("u 1*1",   8'h01, 8'h01, 1'b0, 16'h0001, 1'b0);
      op("u 0*1",   8'h00, 8'h01, 1'b0, 16'h0000, 1'b0);
      op("u 1*0",   8'h01, 8'h00, 1'b0, 16'h0000, 1'b0);
      op("u FE*2",  8'hFE, 8'h02, 1'b0, 16'h01FC, 1'b0);
      op("u FF*FF", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);
      @(negedge cclk);
      check("done single cycle", 64'(done), 64'h0);
      op("s FE*2",  8'hFE, 8'h02, 1'b1, 16'hFFFC, 1'b0);
      op("s 80*80", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
      op("s 80*7F", 8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0);

      // start held high: each op accepted on the previous done cycle,
      // operands scrambled during CALC.
      op("hold 12*34", 8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1);
      op("hold F0*0F", 8'hF0, 8'h0F, 1'b1, 16'hFF10, 1'b1);
      op("hold 7F*81", 8'h7F, 8'h81, 1'b1, 16'hC0FF, 1'b1);
      op("hold AB*CD", 8'hAB, 8'hCD, 1'b0, 16'h88EF, 1'b1);
      start = 1'b0;

      // Reset on the 4th CALC edge aborts the operation.
      start     = 1'b1;
      X         = 8'd3;
      Y         = 8'd5;
      sign_mode = 1'b0;
      @(posedge cclk);
      start = 1'b0;
      repeat (4) @(negedge cclk);
      rst = 1'b1;
      @(negedge cclk);
      rst = 1'b0;
      check("abort Z", 64'(Z), 64'h0);
      check("abort busy/done", {62'd0, busy, done}, 64'h0);
      done_seen = 0;
      repeat (15) begin
         @(negedge cclk);
         if (done) done_seen++;
      end
      check("abort no done", 64'(done_seen), 64'h0);
      op("after abort 3*5", 8'd3, 8'd5, 1'b0, 16'h000F, 1'b0);

      // Randomised vectors, both modes, against the golden product.
      for (int i = 0; i < 1000; i++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         rs = 1'($urandom);
         run_op(rx, ry, rs, 1'b0, z, lat, bn);
         check("random product", 64'(z), 64'(golden(rx, ry, rs)));
      end

      start = 1'b0;
      repeat (3) @(negedge cclk);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
